// File: rtl/memory_cycle_if.sv
// -----------------------------------------------------------------------------
// memory_cycle_if
// Data-memory port bundle between the MEM stage and the data memory.
//   master : the MEM stage (drives request, write enable, address, data, lanes)
//   slave  : the data memory (returns read word and completion strobe)
// Signals
//   DMemReq    access request, held until DMemAck
//   DMemWe     1 store, 0 load
//   DMemAddr   word-aligned address {addr[31:2],2'b00}
//   DMemWData  store data replicated across byte lanes
//   DMemBe     byte enables
//   DMemRData  read word, valid while DMemAck is high
//   DMemAck    access completes in this cycle
// -----------------------------------------------------------------------------
interface memory_cycle_if;
  logic        DMemReq;
  logic        DMemWe;
  logic [31:0] DMemAddr;
  logic [31:0] DMemWData;
  logic [3:0]  DMemBe;
  logic [31:0] DMemRData;
  logic        DMemAck;

  modport master (
    output DMemReq, DMemWe, DMemAddr, DMemWData, DMemBe,
    input  DMemRData, DMemAck
  );

  modport slave (
    input  DMemReq, DMemWe, DMemAddr, DMemWData, DMemBe,
    output DMemRData, DMemAck
  );
endinterface

// File: rtl/memory_cycle.sv
// -----------------------------------------------------------------------------
// memory_cycle
// RV32I MEM stage plus the MEM/WB pipeline register. Loads and stores are sent
// to data memory over a req/ack handshake; upstream is stalled while an access
// is outstanding. Load data is lane-selected and sign/zero-extended, and every
// value the writeback mux needs is registered.
//
// Optional feature macro: MEMORY_MISALIGN_TRAP_EN
//   defined   : misaligned accesses are not issued; MEM/WB receives a slot with
//               ValidW=1, RegWriteW=0 and MisalignM pulses for one cycle.
//   undefined : MisalignM is 0; misaligned accesses proceed and halfword lanes
//               wrap inside the word (offset 3 uses lanes 3 and 0).
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-low reset
//   ValidM..PCPlus4M    EX/MEM register contents
//   dmem                data-memory port (memory_cycle_if.master)
//   StallM              combinational hold for IF..EX/MEM
//   MisalignM           registered misaligned-access flag
//   ValidW..PCPlus4W    MEM/WB register outputs
// -----------------------------------------------------------------------------
module memory_cycle #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      funct3M,
  input  logic [4:0]      RD_M,
  input  logic [XLEN-1:0] ALU_ResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  memory_cycle_if.master  dmem,
  output logic            StallM,
  output logic            MisalignM,
  output logic            ValidW,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [4:0]      RD_W,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic        mem_op_s;
  logic        is_load_s;
  logic        is_byte_s;
  logic        is_half_s;
  logic        trap_s;
  logic        issue_s;
  logic        req_s;
  logic        stall_s;
  logic        done_s;
  logic [1:0]  addr_lo_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] load_data_s;

  // Rotate a 4-bit lane mask left by n lanes (halfword lanes wrap in the word).
  function automatic logic [3:0] rotl4(input logic [3:0] v, input logic [1:0] n);
    logic [3:0] r;
    case (n)
      2'd0:    r = v;
      2'd1:    r = {v[2:0], v[3]};
      2'd2:    r = {v[1:0], v[3:2]};
      2'd3:    r = {v[0], v[3:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Rotate the read word right by n bytes so the addressed lane lands in [7:0].
  function automatic logic [31:0] rotr_bytes(input logic [31:0] v, input logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd0:    r = v;
      2'd1:    r = {v[7:0],  v[31:8]};
      2'd2:    r = {v[15:0], v[31:16]};
      2'd3:    r = {v[23:0], v[31:24]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Whole-word accesses are the fallback so undefined load sizes behave as LW.
  assign addr_lo_s = ALU_ResultM[1:0];
  assign is_byte_s = (funct3M[1:0] == 2'b00);
  assign is_half_s = (funct3M[1:0] == 2'b01);
  assign is_load_s = (ResultSrcM == 2'b01);
  assign mem_op_s  = ValidM & (MemWriteM | is_load_s);

`ifdef MEMORY_MISALIGN_TRAP_EN
  assign trap_s = mem_op_s &
                  ((is_half_s & addr_lo_s[0]) |
                   (~is_byte_s & ~is_half_s & (addr_lo_s != 2'b00)));
`else
  assign trap_s = 1'b0;
`endif

  assign issue_s = mem_op_s & ~trap_s;

  // Handshake FSM: request, stall and completion decode.
  always_comb begin
    state_next_s = state_r;
    req_s        = 1'b0;
    stall_s      = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          req_s = 1'b1;
          if (dmem.DMemAck) begin
            done_s = 1'b1;
          end else begin
            stall_s      = 1'b1;
            state_next_s = ST_WAIT;
          end
        end else begin
          req_s = 1'b0;
        end
      end
      ST_WAIT: begin
        // EX/MEM is held stable, so the request stays asserted until ack.
        req_s = 1'b1;
        if (dmem.DMemAck) begin
          done_s       = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset aborts any outstanding access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Store lane enables and lane-replicated store data; loads read all lanes.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = WriteDataM;
    if (!MemWriteM) begin
      be_s    = 4'b1111;
      wdata_s = WriteDataM;
    end else if (is_byte_s) begin
      be_s    = 4'b0001 << addr_lo_s;
      wdata_s = {4{WriteDataM[7:0]}};
    end else if (is_half_s) begin
      be_s    = rotl4(4'b0011, addr_lo_s);
      wdata_s = {2{WriteDataM[15:0]}};
    end else begin
      be_s    = 4'b1111;
      wdata_s = WriteDataM;
    end
  end

  // Load formatting: select the addressed byte/half then extend; words pass whole.
  always_comb begin
    logic [31:0] rot_v;
    rot_v       = rotr_bytes(dmem.DMemRData, addr_lo_s);
    load_data_s = dmem.DMemRData;
    if (is_byte_s) begin
      load_data_s = {{24{rot_v[7] & ~funct3M[2]}}, rot_v[7:0]};
    end else if (is_half_s) begin
      load_data_s = {{16{rot_v[15] & ~funct3M[2]}}, rot_v[15:0]};
    end else begin
      load_data_s = dmem.DMemRData;
    end
  end

  assign dmem.DMemReq   = req_s;
  assign dmem.DMemWe    = MemWriteM;
  assign dmem.DMemAddr  = {ALU_ResultM[31:2], 2'b00};
  assign dmem.DMemWData = wdata_s;
  assign dmem.DMemBe    = be_s;
  assign StallM         = stall_s;

  // MEM/WB pipeline register; a stall inserts a bubble at every edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ValidW      <= 1'b0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RD_W        <= 5'd0;
      ALU_ResultW <= 32'h0000_0000;
      ReadDataW   <= 32'h0000_0000;
      PCPlus4W    <= RESET_PC;
      MisalignM   <= 1'b0;
    end else if (stall_s) begin
      ValidW    <= 1'b0;
      RegWriteW <= 1'b0;
      MisalignM <= 1'b0;
    end else begin
      ValidW      <= ValidM;
      RegWriteW   <= ValidM & RegWriteM & ~trap_s;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      ALU_ResultW <= ALU_ResultM;
      PCPlus4W    <= PCPlus4M;
      MisalignM   <= trap_s;
      if (done_s && is_load_s) begin
        ReadDataW <= load_data_s;
      end else begin
        ReadDataW <= ReadDataW;
      end
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// -----------------------------------------------------------------------------
// tb_memory_cycle
// Directed bench for memory_cycle. Inputs change 1 time unit after a rising
// edge; combinational outputs are observed on the falling edge and registered
// outputs 1 time unit after the next rising edge.
// -----------------------------------------------------------------------------
module tb_memory_cycle;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ValidM = 1'b0;
  logic        RegWriteM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic [2:0]  funct3M = 3'b000;
  logic [4:0]  RD_M = 5'd0;
  logic [31:0] ALU_ResultM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] PCPlus4M = 32'h0;
  logic        StallM;
  logic        MisalignM;
  logic        ValidW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;

  int n_checks = 0;
  int n_fail   = 0;

  memory_cycle_if dmem_if ();

  memory_cycle #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .ValidM      (ValidM),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .funct3M     (funct3M),
    .RD_M        (RD_M),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .PCPlus4M    (PCPlus4M),
    .dmem        (dmem_if.master),
    .StallM      (StallM),
    .MisalignM   (MisalignM),
    .ValidW      (ValidW),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .PCPlus4W    (PCPlus4W)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    dmem_if.DMemAck   = 1'b0;
    dmem_if.DMemRData = 32'h0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    check("rst_validw",   {31'd0, ValidW},     32'd0);
    check("rst_regwritew",{31'd0, RegWriteW},  32'd0);
    check("rst_resultsrc",{30'd0, ResultSrcW}, 32'd0);
    check("rst_rdw",      {27'd0, RD_W},       32'd0);
    check("rst_aluw",     ALU_ResultW,         32'd0);
    check("rst_readw",    ReadDataW,           32'd0);
    check("rst_pcplus4w", PCPlus4W,            32'd0);
    check("rst_misalign", {31'd0, MisalignM},  32'd0);
    check("rst_req",      {31'd0, dmem_if.DMemReq}, 32'd0);
    check("rst_stall",    {31'd0, StallM},     32'd0);
    rst = 1'b1;

    // ALU op passes through in one cycle
    ValidM = 1'b1; RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b00;
    RD_M = 5'd5; ALU_ResultM = 32'h1234; PCPlus4M = 32'h104;
    @(negedge clk);
    check("alu_stall", {31'd0, StallM}, 32'd0);
    check("alu_req",   {31'd0, dmem_if.DMemReq}, 32'd0);
    step();
    check("alu_regwritew", {31'd0, RegWriteW}, 32'd1);
    check("alu_validw",    {31'd0, ValidW},    32'd1);
    check("alu_rdw",       {27'd0, RD_W},      32'd5);
    check("alu_aluw",      ALU_ResultW,        32'h1234);
    check("alu_pcplus4w",  PCPlus4W,           32'h104);

    // LB 0x1003 with three wait cycles
    ResultSrcM = 2'b01; funct3M = 3'b000; RD_M = 5'd7; ALU_ResultM = 32'h1003;
    PCPlus4M = 32'h108;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lb_stall", {31'd0, StallM}, 32'd1);
      check("lb_req",   {31'd0, dmem_if.DMemReq}, 32'd1);
      check("lb_we",    {31'd0, dmem_if.DMemWe}, 32'd0);
      check("lb_addr",  dmem_if.DMemAddr, 32'h1000);
      check("lb_be",    {28'd0, dmem_if.DMemBe}, 32'hF);
      step();
      check("lb_bubble_valid", {31'd0, ValidW},    32'd0);
      check("lb_bubble_rw",    {31'd0, RegWriteW}, 32'd0);
    end
    dmem_if.DMemAck = 1'b1; dmem_if.DMemRData = 32'h80FF_0000;
    @(negedge clk);
    check("lb_ack_stall", {31'd0, StallM}, 32'd0);
    check("lb_ack_addr",  dmem_if.DMemAddr, 32'h1000);
    step();
    check("lb_readw",  ReadDataW, 32'hFFFF_FF80);
    check("lb_validw", {31'd0, ValidW}, 32'd1);
    check("lb_rdw",    {27'd0, RD_W}, 32'd7);
    check("lb_srcw",   {30'd0, ResultSrcW}, 32'd1);

    // SH 0x2002, ack in the request cycle
    RegWriteM = 1'b0; MemWriteM = 1'b1; ResultSrcM = 2'b00; funct3M = 3'b001;
    ALU_ResultM = 32'h2002; WriteDataM = 32'hAAAA_BEEF;
    @(negedge clk);
    check("sh_be",    {28'd0, dmem_if.DMemBe}, 32'hC);
    check("sh_wdata", dmem_if.DMemWData, 32'hBEEF_BEEF);
    check("sh_we",    {31'd0, dmem_if.DMemWe}, 32'd1);
    check("sh_req",   {31'd0, dmem_if.DMemReq}, 32'd1);
    check("sh_stall", {31'd0, StallM}, 32'd0);
    check("sh_addr",  dmem_if.DMemAddr, 32'h2000);
    step();
    check("sh_validw", {31'd0, ValidW}, 32'd1);
    check("sh_rww",    {31'd0, RegWriteW}, 32'd0);

    // SB 0x2001
    funct3M = 3'b000; ALU_ResultM = 32'h2001; WriteDataM = 32'h1234_565A;
    @(negedge clk);
    check("sb_be",    {28'd0, dmem_if.DMemBe}, 32'h2);
    check("sb_wdata", dmem_if.DMemWData, 32'h5A5A_5A5A);
    step();

    // LHU / LH 0x2002
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b101;
    ALU_ResultM = 32'h2002; dmem_if.DMemRData = 32'h8001_1234;
    @(negedge clk);
    check("lhu_be", {28'd0, dmem_if.DMemBe}, 32'hF);
    step();
    check("lhu_readw", ReadDataW, 32'h0000_8001);
    funct3M = 3'b001;
    step();
    check("lh_readw", ReadDataW, 32'hFFFF_8001);

    // Ack with no request is ignored
    ValidM = 1'b0;
    @(negedge clk);
    check("idle_ack_req",   {31'd0, dmem_if.DMemReq}, 32'd0);
    check("idle_ack_stall", {31'd0, StallM}, 32'd0);
    step();
    check("idle_ack_validw", {31'd0, ValidW}, 32'd0);
    check("idle_ack_readw",  ReadDataW, 32'hFFFF_8001);
    dmem_if.DMemAck = 1'b0;

    // Reset while waiting, then a late ack
    ValidM = 1'b1; funct3M = 3'b010; ALU_ResultM = 32'h4000;
    @(negedge clk);
    check("rw_stall", {31'd0, StallM}, 32'd1);
    step();
    rst = 1'b0; ValidM = 1'b0;
    step();
    rst = 1'b1; dmem_if.DMemAck = 1'b1;
    @(negedge clk);
    check("rw_req",   {31'd0, dmem_if.DMemReq}, 32'd0);
    check("rw_stall2",{31'd0, StallM}, 32'd0);
    step();
    check("rw_validw", {31'd0, ValidW}, 32'd0);
    check("rw_readw",  ReadDataW, 32'd0);
    dmem_if.DMemAck = 1'b0;

    // Misaligned LW 0x3001
    ValidM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 2'b01; funct3M = 3'b010;
    ALU_ResultM = 32'h3001; dmem_if.DMemRData = 32'h1122_3344;
`ifdef MEMORY_MISALIGN_TRAP_EN
    @(negedge clk);
    check("mis_req",   {31'd0, dmem_if.DMemReq}, 32'd0);
    check("mis_stall", {31'd0, StallM}, 32'd0);
    step();
    check("mis_flag",   {31'd0, MisalignM}, 32'd1);
    check("mis_rww",    {31'd0, RegWriteW}, 32'd0);
    check("mis_validw", {31'd0, ValidW}, 32'd1);
    ValidM = 1'b0;
    step();
    check("mis_flag_clr", {31'd0, MisalignM}, 32'd0);
`else
    dmem_if.DMemAck = 1'b1;
    @(negedge clk);
    check("mis_req",   {31'd0, dmem_if.DMemReq}, 32'd1);
    check("mis_addr",  dmem_if.DMemAddr, 32'h3000);
    check("mis_stall", {31'd0, StallM}, 32'd0);
    step();
    check("mis_flag", {31'd0, MisalignM}, 32'd0);
    check("mis_rww",  {31'd0, RegWriteW}, 32'd1);
    // LH at offset 3 wraps: lane 3 low byte, lane 0 high byte
    funct3M = 3'b001; ALU_ResultM = 32'h3003;
    step();
    check("mis_lh_wrap", ReadDataW, 32'h0000_4411);
    ValidM = 1'b0; dmem_if.DMemAck = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
